// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared encodings for the instruction/data memory arbiter:
//   - memory-bus transfer types (trans) and protection codes (prot)
//   - bus-owner enum carried down the response pipeline
//   - response pipeline tag (owner + read flag)
//   - is_sequential(): sequential-burst classification of a granted access
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_NSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ  = 2'b11;

    localparam logic [1:0] PROT_FETCH = 2'b10;
    localparam logic [1:0] PROT_DATA  = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    // One slot of the owner pipeline: who issued the access and whether a
    // read-data response is expected for it.
    typedef struct packed {
        owner_e owner;
        logic   read;
    } resp_tag_t;

    // An access continues a burst only if the same requester owned the
    // previous bus cycle and the word address advances by exactly one.
    function automatic logic is_sequential(input owner_e      own,
                                           input owner_e      last_own,
                                           input logic [31:0] a,
                                           input logic [31:0] last_a);
        return (own != OWN_NONE) && (own == last_own) && (a == last_a + 32'd1);
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
// Bundles the fetch requester, data requester and memory-bus signals around
// the arbiter.
//   Fetch side : i_req, i_addr -> i_gnt, i_rvalid, i_rdata, i_abort
//   Data side  : d_req, d_addr, d_wdata, d_write, d_size
//                -> d_gnt, d_rvalid, d_rdata, d_abort
//   Memory bus : addr, wdata, write, size, prot, trans -> rdata, abort
// Modports:
//   master : the arbiter (answers requesters, drives the memory bus)
//   slave  : the environment (requesters and memory controller)
// -----------------------------------------------------------------------------
interface memory_arbiter_if;

    // Fetch requester
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_abort;

    // Data requester
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_write;
    logic        d_size;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_abort;

    // Memory bus
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        size;
    logic [1:0]  prot;
    logic [1:0]  trans;
    logic [31:0] rdata;
    logic        abort;

    modport master (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_abort,
        input  d_req, d_addr, d_wdata, d_write, d_size,
        output d_gnt, d_rvalid, d_rdata, d_abort,
        output addr, wdata, write, size, prot, trans,
        input  rdata, abort
    );

    modport slave (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_abort,
        output d_req, d_addr, d_wdata, d_write, d_size,
        input  d_gnt, d_rvalid, d_rdata, d_abort,
        input  addr, wdata, write, size, prot, trans,
        output rdata, abort
    );

endinterface

// File: rtl/memory_arbiter_priority.sv
// -----------------------------------------------------------------------------
// memory_arbiter_priority
// Combinational grant logic for the memory arbiter. Data wins over fetch.
// Optional starvation guard, enabled by defining MEMORY_ARBITER_STARVE_EN:
// a counter of cycles in which fetch waited while data was granted forces a
// fetch grant once it reaches MAX_WAIT. Without the macro no counter exists
// and fetch may be starved indefinitely.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset (counter only)
//   i_req, d_req   : fetch / data requests
//   i_gnt, d_gnt   : one-hot-or-zero grants, combinational
// -----------------------------------------------------------------------------
module memory_arbiter_priority #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

`ifdef MEMORY_ARBITER_STARVE_EN

    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] wait_cnt;
    logic             starved;

    assign starved = (wait_cnt >= CNT_MAX);

    always_comb begin
        // NOTE: both grants get a default before any branch so no path
        // through this block leaves a latch behind.
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (i_req && (starved || !d_req)) begin
            i_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end
    end

    // Counter never passes CNT_MAX: once there, a pending fetch wins and the
    // grant clears it; with no fetch pending it simply holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (i_gnt) begin
            wait_cnt <= '0;
        end else if (i_req && d_gnt) begin
            wait_cnt <= wait_cnt + CNT_ONE;
        end
    end

`else

    always_comb begin
        // NOTE: both grants get a default before any branch so no path
        // through this block leaves a latch behind.
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (d_req) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end
    end

    // Pure fixed priority keeps no state; clock, reset and MAX_WAIT are only
    // consumed by the starvation-guard build.
    logic unused_tie;
    assign unused_tie = clk | reset | (MAX_WAIT == 0);

`endif

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Shares one single-ported memory bus between the instruction-fetch path and
// the data (load/store) path. At most one access is granted per cycle; the
// granted access is registered onto the bus at the next edge, classified as
// nonsequential or sequential, and tracked through a two-stage owner pipeline
// so that rdata/abort are routed back to the requester that issued it.
// Build option: MEMORY_ARBITER_STARVE_EN enables the fetch starvation guard
// inside memory_arbiter_priority (MAX_WAIT cycles).
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : memory_arbiter_if.master (requesters + memory bus)
// -----------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    memory_arbiter_if.master      bus
);

    logic i_gnt;
    logic d_gnt;

    memory_arbiter_priority #(
        .MAX_WAIT (MAX_WAIT)
    ) u_priority (
        .clk   (clk),
        .reset (reset),
        .i_req (bus.i_req),
        .d_req (bus.d_req),
        .i_gnt (i_gnt),
        .d_gnt (d_gnt)
    );

    assign bus.i_gnt = i_gnt;
    assign bus.d_gnt = d_gnt;

    // Registered bus state and burst-tracking state.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        size_q;
    logic [1:0]  prot_q;
    logic [1:0]  trans_q;
    owner_e      last_owner;
    logic [31:0] last_addr;

    // Owner pipeline: bus_tag follows the access on the bus, resp_tag the
    // cycle in which the memory returns its response.
    resp_tag_t   bus_tag;
    resp_tag_t   resp_tag;

    // Next bus contents for the access being granted this cycle.
    owner_e      gnt_owner;
    logic        gnt_read;
    logic [31:0] nxt_addr;
    logic [31:0] nxt_wdata;
    logic        nxt_write;
    logic        nxt_size;
    logic [1:0]  nxt_prot;
    logic [1:0]  nxt_trans;

    always_comb begin
        gnt_owner = OWN_NONE;
        gnt_read  = 1'b0;
        nxt_addr  = addr_q;
        nxt_wdata = wdata_q;
        nxt_write = 1'b0;
        nxt_size  = size_q;
        nxt_prot  = prot_q;
        nxt_trans = TRANS_IDLE;

        if (i_gnt) begin
            gnt_owner = OWN_FETCH;
            gnt_read  = 1'b1;
            nxt_addr  = bus.i_addr;
            nxt_size  = 1'b1;
            nxt_prot  = PROT_FETCH;
        end else if (d_gnt) begin
            gnt_owner = OWN_DATA;
            gnt_read  = !bus.d_write;
            nxt_addr  = bus.d_addr;
            nxt_wdata = bus.d_wdata;
            nxt_write = bus.d_write;
            nxt_size  = bus.d_size;
            nxt_prot  = PROT_DATA;
        end

        if (gnt_owner != OWN_NONE) begin
            nxt_trans = is_sequential(gnt_owner, last_owner, nxt_addr, last_addr)
                        ? TRANS_SEQ : TRANS_NSEQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            size_q     <= 1'b1;
            prot_q     <= PROT_FETCH;
            trans_q    <= TRANS_IDLE;
            last_owner <= OWN_NONE;
            last_addr  <= '0;
            bus_tag    <= '{owner: OWN_NONE, read: 1'b0};
            resp_tag   <= '{owner: OWN_NONE, read: 1'b0};
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, regardless of statement order.
            addr_q     <= nxt_addr;
            wdata_q    <= nxt_wdata;
            write_q    <= nxt_write;
            size_q     <= nxt_size;
            prot_q     <= nxt_prot;
            trans_q    <= nxt_trans;
            // An idle cycle records OWN_NONE, which breaks any burst.
            last_owner <= gnt_owner;
            if (gnt_owner != OWN_NONE) begin
                last_addr <= nxt_addr;
            end
            bus_tag    <= '{owner: gnt_owner, read: gnt_read};
            resp_tag   <= bus_tag;
        end
    end

    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.write = write_q;
    assign bus.size  = size_q;
    assign bus.prot  = prot_q;
    assign bus.trans = trans_q;

    // Read data fans out to both requesters; only the owner's valid/abort fire.
    assign bus.i_rdata  = bus.rdata;
    assign bus.d_rdata  = bus.rdata;
    assign bus.i_rvalid = (resp_tag.owner == OWN_FETCH) && resp_tag.read;
    assign bus.d_rvalid = (resp_tag.owner == OWN_DATA)  && resp_tag.read;
    assign bus.i_abort  = (resp_tag.owner == OWN_FETCH) && bus.abort;
    assign bus.d_abort  = (resp_tag.owner == OWN_DATA)  && bus.abort;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
// Self-checking bench for memory_arbiter: a vector table for grants and bus
// encoding, a scoreboard queue for read responses, and hand-written sequences
// for starvation, abort routing and reset in flight. Expectations for the
// starvation sequence follow MEMORY_ARBITER_STARVE_EN.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_arbiter_if bus ();

    memory_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // ---------------- memory model and reference memory ----------------
    logic [31:0] mem     [512];
    logic [31:0] ref_mem [512];
    logic        abort_force = 1'b0;

    assign bus.abort = abort_force;

    always @(posedge clk) begin
        if (bus.trans[1]) begin
            if (bus.write) mem[bus.addr[8:0]] <= bus.wdata;
            else           bus.rdata <= mem[bus.addr[8:0]];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        owner_e      owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   pcyc = 0;

    always @(posedge clk) pcyc++;

    always @(negedge clk) begin : monitor
        logic exp_i;
        logic exp_d;
        if (reset) begin
            sb.delete();
        end else begin
            exp_i = (sb.size() > 0) && (sb[0].due == pcyc) && (sb[0].owner == OWN_FETCH);
            exp_d = (sb.size() > 0) && (sb[0].due == pcyc) && (sb[0].owner == OWN_DATA);
            check($sformatf("i_rvalid@%0d", pcyc), {31'b0, bus.i_rvalid}, {31'b0, exp_i});
            check($sformatf("d_rvalid@%0d", pcyc), {31'b0, bus.d_rvalid}, {31'b0, exp_d});
            if (exp_i) check($sformatf("i_rdata@%0d", pcyc), bus.i_rdata, sb[0].data);
            if (exp_d) check($sformatf("d_rdata@%0d", pcyc), bus.d_rdata, sb[0].data);
            if (exp_i || exp_d) void'(sb.pop_front());
        end
    end

    // One cycle of stimulus: drive after the edge, push expected responses
    // for the access that should be granted, check grants at the negedge.
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [31:0] da,
                        input logic [31:0] dwd, input logic dw, input logic ds,
                        input logic exp_ig, input logic exp_dg, input string tag);
        @(posedge clk);
        #1;
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        bus.d_write = dw;
        bus.d_size  = ds;
        if (exp_ig) begin
            sb.push_back('{OWN_FETCH, ref_mem[ia[8:0]], pcyc + 2});
        end else if (exp_dg) begin
            if (dw) ref_mem[da[8:0]] = dwd;
            else    sb.push_back('{OWN_DATA, ref_mem[da[8:0]], pcyc + 2});
        end
        @(negedge clk);
        check({"i_gnt ", tag}, {31'b0, bus.i_gnt}, {31'b0, exp_ig});
        check({"d_gnt ", tag}, {31'b0, bus.d_gnt}, {31'b0, exp_dg});
    endtask

    task automatic idle(input string tag);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        d_write;
        logic        d_size;
        logic        exp_i_gnt;
        logic        exp_d_gnt;
        logic [1:0]  exp_trans;
    } vec_t;

    localparam int NV = 14;
    vec_t        vecs [NV];
    logic [31:0] exp_wdata = 32'h0;

    // Bus contents expected one cycle after the row's grant.
    task automatic check_bus(input vec_t v, input int k);
        string t;
        t = $sformatf("row%0d", k);
        check({"trans ", t}, {30'b0, bus.trans}, {30'b0, v.exp_trans});
        if (v.exp_i_gnt) begin
            check({"addr ", t},  bus.addr, v.i_addr);
            check({"write ", t}, {31'b0, bus.write}, 32'd0);
            check({"prot ", t},  {30'b0, bus.prot}, {30'b0, PROT_FETCH});
            check({"size ", t},  {31'b0, bus.size}, 32'd1);
            check({"wdata ", t}, bus.wdata, exp_wdata);
        end else if (v.exp_d_gnt) begin
            exp_wdata = v.d_wdata;
            check({"addr ", t},  bus.addr, v.d_addr);
            check({"write ", t}, {31'b0, bus.write}, {31'b0, v.d_write});
            check({"prot ", t},  {30'b0, bus.prot}, {30'b0, PROT_DATA});
            check({"size ", t},  {31'b0, bus.size}, {31'b0, v.d_size});
            check({"wdata ", t}, bus.wdata, exp_wdata);
        end else begin
            check({"write ", t}, {31'b0, bus.write}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic fetch_pending;
        logic exp_ig;

        for (int i = 0; i < 512; i++) begin
            mem[i]     = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end

        //         ir    i_addr     dr    d_addr      d_wdata       dw    ds    eig   edg   trans
        vecs[0]  = '{1'b1, 32'h0,    1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, TRANS_NSEQ};
        vecs[1]  = '{1'b1, 32'h1,    1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, TRANS_SEQ};
        vecs[2]  = '{1'b1, 32'h2,    1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, TRANS_SEQ};
        vecs[3]  = '{1'b1, 32'h3,    1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, TRANS_SEQ};
        vecs[4]  = '{1'b1, 32'h4,    1'b1, 32'h100,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, TRANS_NSEQ};
        vecs[5]  = '{1'b1, 32'h4,    1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, TRANS_NSEQ};
        vecs[6]  = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0, TRANS_IDLE};
        vecs[7]  = '{1'b0, 32'h0,    1'b1, 32'h20,   32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1, TRANS_NSEQ};
        vecs[8]  = '{1'b0, 32'h0,    1'b1, 32'h20,   32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, TRANS_NSEQ};
        vecs[9]  = '{1'b0, 32'h0,    1'b1, 32'h21,   32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, TRANS_SEQ};
        vecs[10] = '{1'b1, 32'h22,   1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, TRANS_NSEQ};
        vecs[11] = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0, TRANS_IDLE};
        vecs[12] = '{1'b1, 32'h23,   1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, TRANS_NSEQ};
        vecs[13] = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0, TRANS_IDLE};

        // ---------------- reset state ----------------
        reset       = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_write = 1'b0;
        bus.d_size  = 1'b0;
        bus.rdata   = 32'h0;
        #12;
        check("reset addr",     bus.addr, 32'h0);
        check("reset wdata",    bus.wdata, 32'h0);
        check("reset write",    {31'b0, bus.write}, 32'd0);
        check("reset size",     {31'b0, bus.size}, 32'd1);
        check("reset prot",     {30'b0, bus.prot}, {30'b0, PROT_FETCH});
        check("reset trans",    {30'b0, bus.trans}, {30'b0, TRANS_IDLE});
        check("reset i_rvalid", {31'b0, bus.i_rvalid}, 32'd0);
        check("reset d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ---------------- table-driven grants and bus encoding ----------------
        for (int k = 0; k < NV; k++) begin
            step(vecs[k].i_req, vecs[k].i_addr, vecs[k].d_req, vecs[k].d_addr,
                 vecs[k].d_wdata, vecs[k].d_write, vecs[k].d_size,
                 vecs[k].exp_i_gnt, vecs[k].exp_d_gnt, $sformatf("row%0d", k));
            if (k > 0) check_bus(vecs[k-1], k - 1);
        end
        idle("row_tail");
        check_bus(vecs[NV-1], NV - 1);

        // ---------------- starvation: data held, fetch pending ----------------
        fetch_pending = 1'b1;
        for (int c = 1; c <= 8; c++) begin
`ifdef MEMORY_ARBITER_STARVE_EN
            exp_ig = (c == MAX_WAIT + 1);
`else
            exp_ig = 1'b0;
`endif
            step(fetch_pending, 32'h80, 1'b1, 32'h40 + 32'(c), 32'h0, 1'b0, 1'b1,
                 exp_ig, !exp_ig, $sformatf("starve%0d", c));
            if (exp_ig) fetch_pending = 1'b0;
        end
        idle("starve_end");

        // ---------------- abort routed to fetch ----------------
        step(1'b1, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "abort_fetch");
        idle("abort_fetch_gap");
        @(posedge clk);
        #1 abort_force = 1'b1;
        @(negedge clk);
        check("abort_fetch i_abort",  {31'b0, bus.i_abort}, 32'd1);
        check("abort_fetch i_rvalid", {31'b0, bus.i_rvalid}, 32'd1);
        check("abort_fetch d_abort",  {31'b0, bus.d_abort}, 32'd0);
        @(posedge clk);
        #1 abort_force = 1'b0;

        // ---------------- abort on a data write: no rvalid ----------------
        step(1'b0, 32'h0, 1'b1, 32'h44, 32'h55, 1'b1, 1'b1, 1'b0, 1'b1, "abort_write");
        idle("abort_write_gap");
        @(posedge clk);
        #1 abort_force = 1'b1;
        @(negedge clk);
        check("abort_write d_abort",  {31'b0, bus.d_abort}, 32'd1);
        check("abort_write d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        check("abort_write i_abort",  {31'b0, bus.i_abort}, 32'd0);
        @(posedge clk);
        #1 abort_force = 1'b0;

        // ---------------- reset one cycle after a data read grant ----------------
        step(1'b0, 32'h0, 1'b1, 32'h30, 32'hCAFE0000, 1'b0, 1'b0, 1'b0, 1'b1, "rst_read");
        @(posedge clk);
        #1;
        check("rst_read bus trans before reset", {30'b0, bus.trans}, {30'b0, TRANS_NSEQ});
        bus.d_req = 1'b0;
        reset     = 1'b1;
        #1;
        check("rst addr",  bus.addr, 32'h0);
        check("rst wdata", bus.wdata, 32'h0);
        check("rst write", {31'b0, bus.write}, 32'd0);
        check("rst size",  {31'b0, bus.size}, 32'd1);
        check("rst prot",  {30'b0, bus.prot}, {30'b0, PROT_FETCH});
        check("rst trans", {30'b0, bus.trans}, {30'b0, TRANS_IDLE});
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            idle($sformatf("post_rst%0d", c));
            check($sformatf("post_rst d_rvalid%0d", c), {31'b0, bus.d_rvalid}, 32'd0);
        end

        // ---------------- drain ----------------
        for (int c = 0; c < 3; c++) idle("drain");
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-ported memory interface (addr/wdata/rdata/abort/write/size/prot/trans) between the processor's instruction-fetch path and its data (load/store) path. Grants at most one access per cycle, drives registered memory-bus signals, classifies each access as nonsequential or sequential, and routes read data and abort back to the owning requester. It sits between `processor` and `memory_controller`, replacing the processor's direct drive of the bus.

## Interface
- `MAX_WAIT`, 4: consecutive cycles fetch may be denied before it is forced to win (starvation guard).
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `i_req` in 1: fetch request; `i_addr` held stable until granted.
- `i_addr` in 32: fetch word address.
- `i_gnt` out 1: fetch granted this cycle (combinational).
- `i_rvalid` out 1: fetch read data valid.
- `i_rdata` out 32: fetch read data.
- `i_abort` out 1: fetch access aborted; qualified by `i_rvalid`.
- `d_req` in 1: data request; `d_addr`, `d_wdata`, `d_write`, `d_size` held until granted.
- `d_addr` in 32, `d_wdata` in 32, `d_write` in 1, `d_size` in 1: data access attributes.
- `d_gnt` out 1: data granted this cycle (combinational).
- `d_rvalid` out 1: data read data valid (reads only).
- `d_rdata` out 32: data read data.
- `d_abort` out 1: data access aborted; pulses in the response cycle of reads and writes.
- `addr` out 32, `wdata` out 32, `write` out 1, `size` out 1, `prot` out 2, `trans` out 2: memory bus, all registered.
- `rdata` in 32, `abort` in 1: memory response, valid the cycle after the memory samples the access.

## Operation
- Grant: data wins over fetch when both request; exception: fetch-starvation counter (see Configuration).
- At most one of `i_gnt`/`d_gnt` high; a grant completes the request handshake in that cycle.
- Granted access is registered onto the memory bus at the next edge. With no grant, `trans` = 2'b00 (idle), and `write` = 0.
- `trans` = 2'b11 (sequential) when the granted owner equals the previous bus owner and the address equals previous address + 1. Otherwise 2'b10 (nonsequential). After an idle cycle the next access is nonsequential.
- `prot`: fetch 2'b10, data 2'b11. `size`: fetch 1 (word), data `d_size`. `wdata`: `d_wdata` for data, unchanged for fetch.
- A two-stage owner pipeline {NONE, FETCH, DATA} + read flag tracks each access from bus cycle to response cycle. `rdata` is passed combinationally to both `*_rdata`. `*_rvalid` is asserted only for the owner of a read in its response cycle. `abort` is routed likewise to `*_abort`.
- Back-to-back grants every cycle are supported; responses return in grant order.
- Reset mid-operation: the owner pipeline is cleared, and no `rvalid`/`abort` is emitted for accesses in flight.
- Reset values: `addr` 0, `wdata` 0, `write` 0, `size` 1, `prot` 2'b10, `trans` 2'b00, all `*_rvalid`/`*_abort` 0, starvation counter 0, last owner NONE, last address 0.

## Timing
- Cycle 0: req high → gnt high (combinational).
- Edge 1: bus registered.
- Edge 2: memory samples.
- Cycle 2 after edge 2: `rvalid`/`rdata`/`abort` to requester.
- Read latency is 2 cycles from grant; throughput is 1 access/cycle.
- Requesters must not change attributes while req is high and gnt is low.

## Configuration
- `MEMORY_ARBITER_STARVE_EN` defined: a counter increments each cycle in which `i_req` is high and `d_gnt` is high, and clears on `i_gnt`. When the counter reaches `MAX_WAIT`, fetch is granted next even if `d_req` is high, and the counter clears.
- Undefined: pure fixed priority; fetch can be starved indefinitely; no counter is synthesized.

## Structure
- `memory_arbiter_pkg`: `TRANS_IDLE` = 2'b00, `TRANS_NSEQ` = 2'b10, `TRANS_SEQ` = 2'b11; `PROT_FETCH` = 2'b10, `PROT_DATA` = 2'b11; owner enum {OWN_NONE, OWN_FETCH, OWN_DATA}.
- One sub-module `memory_arbiter_priority`: combinational grant logic plus the starvation counter. The top level holds bus registers, sequential detection, and the response pipeline.

## Test plan
- Fetch-only reads at addresses 0,1,2,3: `trans` 10,11,11,11; `i_rvalid` two cycles after each grant with `memory[n]`.
- `i_req` and `d_req` both high, `d_addr`=0x100 read: `d_gnt` first, fetch granted the next cycle; `trans` 10 for both (owner change).
- Data write 0xDEADBEEF to 0x20 then read 0x20 back to back: `write`=1 then 0; `d_rvalid` only for the read, with data 0xDEADBEEF; no rvalid for the write.
- With STARVE_EN and `MAX_WAIT`=4, `d_req` held high continuously with fetch pending: `i_gnt` asserted on the 5th cycle, then data resumes. Without STARVE_EN, `i_gnt` stays 0.
- Force `abort`=1 in a fetch's response cycle: `i_abort`=1 with `i_rvalid`, `d_abort`=0.
- Assert `reset` one cycle after a data read grant: bus returns to its reset values immediately; no `d_rvalid` afterwards.
